// File: rtl/mbus_tx_arbiter_pkg.sv
// rtl/mbus_tx_arbiter_pkg.sv - shared widths, watchdog width and FSM encoding for the MBus TX arbiter
package mbus_tx_arbiter_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int TX_ARB_TO_WIDTH = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREQ,
        ST_WACK,
        ST_RESP,
        ST_RACK,
        ST_DRAIN
    } arb_state_t;

endpackage

// File: rtl/mbus_tx_arbiter_if.sv
// rtl/mbus_tx_arbiter_if.sv - requester-side and node-side TX signals of the MBus TX arbiter
interface mbus_tx_arbiter_if
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]            C_REQ;
    logic [NUM_REQ*ADDR_WIDTH-1:0] C_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] C_DATA;
    logic [NUM_REQ-1:0]            C_PEND;
    logic [NUM_REQ-1:0]            C_PRIORITY;
    logic [NUM_REQ-1:0]            C_ACK;
    logic [NUM_REQ-1:0]            C_DONE;
    logic                          C_SUCC;
    logic                          C_FAIL;
    logic                          C_TIMEOUT;
    logic [ADDR_WIDTH-1:0]         TX_ADDR;
    logic [DATA_WIDTH-1:0]         TX_DATA;
    logic                          TX_PEND;
    logic                          TX_REQ;
    logic                          TX_PRIORITY;
    logic                          TX_RESP_ACK;
    logic                          TX_ACK;
    logic                          TX_SUCC;
    logic                          TX_FAIL;
    logic                          BUSY;

    modport master (
        input  C_REQ, C_ADDR, C_DATA, C_PEND, C_PRIORITY, TX_ACK, TX_SUCC, TX_FAIL,
        output C_ACK, C_DONE, C_SUCC, C_FAIL, C_TIMEOUT,
        output TX_ADDR, TX_DATA, TX_PEND, TX_REQ, TX_PRIORITY, TX_RESP_ACK, BUSY
    );

    modport slave (
        output C_REQ, C_ADDR, C_DATA, C_PEND, C_PRIORITY, TX_ACK, TX_SUCC, TX_FAIL,
        input  C_ACK, C_DONE, C_SUCC, C_FAIL, C_TIMEOUT,
        input  TX_ADDR, TX_DATA, TX_PEND, TX_REQ, TX_PRIORITY, TX_RESP_ACK, BUSY
    );

endinterface

// File: rtl/mbus_rr_picker.sv
// rtl/mbus_rr_picker.sv - combinational round-robin find-first with explicit modulo-N wrap
module mbus_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);

    int           pos;
    logic [W-1:0] sel;

    // Scan from the farthest offset back towards the pointer so the nearest request wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        pos    = 0;
        sel    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            sel = W'(pos);
            if (req[sel]) begin
                onehot      = '0;
                onehot[sel] = 1'b1;
                idx         = sel;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// rtl/mbus_tx_arbiter.sv - message-locked round-robin arbiter for the MBus node TX port; MBUS_TX_ARB_PRIO_EN adds a priority class
module mbus_tx_arbiter
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int                         NUM_REQ = 4,
    parameter logic [TX_ARB_TO_WIDTH-1:0] TIMEOUT = 20'h05fff
) (
    input logic               CLK_EXT,
    input logic               RESETn_local,
    mbus_tx_arbiter_if.master bus
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_t                 state;
    logic [PW-1:0]              gnt;
    logic [PW-1:0]              ptr;
    logic [PW-1:0]              gnt_next;
    logic [TX_ARB_TO_WIDTH-1:0] wd;
    logic                       resp_succ;
    logic                       resp_fail;
    logic [NUM_REQ-1:0]         pick_oh;
    logic [PW-1:0]              pick_idx;
    logic                       pick_valid;
    logic [PW-1:0]              lat_idx;
    logic                       counting;
    logic                       advance;
    logic                       wd_hit;
    logic                       wd_abort;

`ifdef MBUS_TX_ARB_PRIO_EN
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] hi_oh;
    logic [NUM_REQ-1:0] lo_oh;
    logic [PW-1:0]      hi_idx;
    logic [PW-1:0]      lo_idx;
    logic               hi_valid;
    logic               lo_valid;

    assign hi_req = bus.C_REQ & bus.C_PRIORITY;

    mbus_rr_picker #(.N(NUM_REQ), .W(PW)) u_pick_hi (
        .req(hi_req), .ptr(ptr), .onehot(hi_oh), .idx(hi_idx), .valid(hi_valid)
    );
    mbus_rr_picker #(.N(NUM_REQ), .W(PW)) u_pick_lo (
        .req(bus.C_REQ), .ptr(ptr), .onehot(lo_oh), .idx(lo_idx), .valid(lo_valid)
    );

    assign pick_oh    = hi_valid ? hi_oh  : lo_oh;
    assign pick_idx   = hi_valid ? hi_idx : lo_idx;
    assign pick_valid = hi_valid | lo_valid;
`else
    mbus_rr_picker #(.N(NUM_REQ), .W(PW)) u_pick (
        .req(bus.C_REQ), .ptr(ptr), .onehot(pick_oh), .idx(pick_idx), .valid(pick_valid)
    );
`endif

    assign gnt_next = (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + PW'(1);
    assign lat_idx  = (state == ST_IDLE) ? pick_idx : gnt;
    assign counting = (state == ST_WREQ) || (state == ST_WACK) || (state == ST_RESP);
    assign wd_hit   = (wd == TIMEOUT - TX_ARB_TO_WIDTH'(1));
    assign wd_abort = counting && !advance && wd_hit;
    assign bus.BUSY = (state != ST_IDLE);

    // advance marks the cycle a watched state leaves normally; progress beats a coincident timeout.
    always_comb begin
        advance = 1'b0;
        case (state)
            ST_WREQ: advance = bus.TX_ACK;
            ST_WACK: advance = !bus.TX_ACK && (!bus.TX_PEND || bus.C_REQ[gnt]);
            ST_RESP: advance = bus.TX_SUCC || bus.TX_FAIL;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_EXT or negedge RESETn_local) begin
        if (!RESETn_local) begin
            state           <= ST_IDLE;
            gnt             <= '0;
            ptr             <= '0;
            wd              <= '0;
            resp_succ       <= 1'b0;
            resp_fail       <= 1'b0;
            bus.C_ACK       <= '0;
            bus.C_DONE      <= '0;
            bus.C_SUCC      <= 1'b0;
            bus.C_FAIL      <= 1'b0;
            bus.C_TIMEOUT   <= 1'b0;
            bus.TX_ADDR     <= '0;
            bus.TX_DATA     <= '0;
            bus.TX_PEND     <= 1'b0;
            bus.TX_REQ      <= 1'b0;
            bus.TX_PRIORITY <= 1'b0;
            bus.TX_RESP_ACK <= 1'b0;
        end else begin
            bus.C_ACK  <= '0;
            bus.C_DONE <= '0;
            wd         <= (counting && !advance && !wd_hit) ? wd + TX_ARB_TO_WIDTH'(1) : '0;

            if (wd_abort) begin
                bus.TX_REQ       <= 1'b0;
                bus.C_SUCC       <= 1'b0;
                bus.C_FAIL       <= 1'b1;
                bus.C_TIMEOUT    <= 1'b1;
                bus.C_DONE[gnt]  <= 1'b1;
                ptr              <= gnt_next;
                state            <= ST_DRAIN;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.TX_SUCC || bus.TX_FAIL) begin
                            state <= ST_DRAIN;
                        end else if (pick_valid) begin
                            gnt             <= pick_idx;
                            bus.C_ACK       <= pick_oh;
                            bus.TX_ADDR     <= bus.C_ADDR[lat_idx*ADDR_WIDTH +: ADDR_WIDTH];
                            bus.TX_DATA     <= bus.C_DATA[lat_idx*DATA_WIDTH +: DATA_WIDTH];
                            bus.TX_PEND     <= bus.C_PEND[lat_idx];
                            bus.TX_PRIORITY <= bus.C_PRIORITY[lat_idx];
                            state           <= ST_WREQ;
                        end
                    end
                    ST_WREQ: begin
                        if (bus.TX_ACK) begin
                            bus.TX_REQ <= 1'b0;
                            state      <= ST_WACK;
                        end else begin
                            bus.TX_REQ <= 1'b1;
                        end
                    end
                    ST_WACK: begin
                        if (advance && bus.TX_PEND) begin
                            bus.C_ACK[gnt]  <= 1'b1;
                            bus.TX_ADDR     <= bus.C_ADDR[lat_idx*ADDR_WIDTH +: ADDR_WIDTH];
                            bus.TX_DATA     <= bus.C_DATA[lat_idx*DATA_WIDTH +: DATA_WIDTH];
                            bus.TX_PEND     <= bus.C_PEND[lat_idx];
                            bus.TX_PRIORITY <= bus.C_PRIORITY[lat_idx];
                            state           <= ST_WREQ;
                        end else if (advance) begin
                            state <= ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        if (advance) begin
                            resp_succ       <= bus.TX_SUCC;
                            resp_fail       <= bus.TX_FAIL;
                            bus.TX_RESP_ACK <= 1'b1;
                            state           <= ST_RACK;
                        end
                    end
                    ST_RACK: begin
                        if (!bus.TX_SUCC && !bus.TX_FAIL) begin
                            bus.TX_RESP_ACK <= 1'b0;
                            bus.C_DONE[gnt] <= 1'b1;
                            bus.C_SUCC      <= resp_succ && !resp_fail;
                            bus.C_FAIL      <= resp_fail;
                            bus.C_TIMEOUT   <= 1'b0;
                            ptr             <= gnt_next;
                            state           <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        bus.TX_RESP_ACK <= bus.TX_SUCC || bus.TX_FAIL;
                        if (!bus.TX_SUCC && !bus.TX_FAIL && !bus.TX_ACK) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// tb/tb_mbus_tx_arbiter.sv - directed self-checking bench for mbus_tx_arbiter (honours MBUS_TX_ARB_PRIO_EN)
`timescale 1ns/1ps
module tb_mbus_tx_arbiter;

    localparam int N = 4;

    logic CLK_EXT      = 1'b0;
    logic RESETn_local = 1'b0;
    int   checks       = 0;
    int   errors       = 0;
    int   exp_g;
    int   n_hi;
    logic [31:0] mw_data [3];

    mbus_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    mbus_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(20'h00010)) dut (
        .CLK_EXT      (CLK_EXT),
        .RESETn_local (RESETn_local),
        .bus          (bus)
    );

    always #5 CLK_EXT = ~CLK_EXT;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_EXT);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] a, input logic [31:0] d, input logic p);
        bus.C_ADDR[i*32 +: 32] = a;
        bus.C_DATA[i*32 +: 32] = d;
        bus.C_PEND[i]          = p;
    endtask

    // Entered in the cycle after C_ACK; leaves once the arbiter has seen TX_ACK fall.
    task automatic send_word();
        tick();
        chk("wreq_txreq_rise", bus.TX_REQ, 1'b1);
        bus.TX_ACK = 1'b1;
        tick();
        chk("wreq_txreq_drop", bus.TX_REQ, 1'b0);
        bus.TX_ACK = 1'b0;
        tick();
    endtask

    task automatic respond(input logic s, input logic f, input logic [3:0] mask,
                           input logic es, input logic ef);
        bus.TX_SUCC = s;
        bus.TX_FAIL = f;
        tick();
        chk("resp_ack_high", bus.TX_RESP_ACK, 1'b1);
        chk("resp_no_done", bus.C_DONE, 4'b0000);
        bus.TX_SUCC = 1'b0;
        bus.TX_FAIL = 1'b0;
        tick();
        chk("rack_done", bus.C_DONE, mask);
        chk("rack_succ", bus.C_SUCC, es);
        chk("rack_fail", bus.C_FAIL, ef);
        chk("rack_timeout", bus.C_TIMEOUT, 1'b0);
        chk("rack_ack_low", bus.TX_RESP_ACK, 1'b0);
    endtask

    task automatic do_reset();
        RESETn_local = 1'b0;
        tick();
        tick();
        RESETn_local = 1'b1;
    endtask

    initial begin
        bus.C_REQ      = '0;
        bus.C_ADDR     = '0;
        bus.C_DATA     = '0;
        bus.C_PEND     = '0;
        bus.C_PRIORITY = '0;
        bus.TX_ACK     = 1'b0;
        bus.TX_SUCC    = 1'b0;
        bus.TX_FAIL    = 1'b0;
        mw_data[0]     = 32'h1111_0000;
        mw_data[1]     = 32'h2222_0001;
        mw_data[2]     = 32'h3333_0002;

        do_reset();
        chk("reset_txreq", bus.TX_REQ, 1'b0);
        chk("reset_cack", bus.C_ACK, 4'b0000);
        chk("reset_cdone", bus.C_DONE, 4'b0000);
        chk("reset_busy", bus.BUSY, 1'b0);
        chk("reset_respack", bus.TX_RESP_ACK, 1'b0);
        chk("reset_cfail", bus.C_FAIL, 1'b0);
        chk("reset_txaddr", bus.TX_ADDR, 32'h0);

        // Single word from requester 1; TX_REQ two cycles after C_REQ.
        set_word(1, 32'h0000_0050, 32'hDEAD_BEEF, 1'b0);
        bus.C_REQ = 4'b0010;
        tick();
        chk("sw_cack", bus.C_ACK, 4'b0010);
        chk("sw_txreq_early", bus.TX_REQ, 1'b0);
        chk("sw_addr", bus.TX_ADDR, 32'h0000_0050);
        chk("sw_data", bus.TX_DATA, 32'hDEAD_BEEF);
        chk("sw_busy", bus.BUSY, 1'b1);
        bus.C_REQ = 4'b0000;
        send_word();
        respond(1'b1, 1'b0, 4'b0010, 1'b1, 1'b0);
        tick();
        chk("sw_done_pulse", bus.C_DONE, 4'b0000);
        chk("sw_succ_held", bus.C_SUCC, 1'b1);
        chk("sw_idle", bus.BUSY, 1'b0);

        // Three-word message from requester 2 while requester 0 waits; pointer is now 2.
        set_word(0, 32'h0000_0040, 32'h0A0A_0A0A, 1'b0);
        set_word(2, 32'h0000_0070, mw_data[0], 1'b1);
        bus.C_REQ = 4'b0101;
        tick();
        for (int w = 0; w < 3; w++) begin
            chk("mw_cack", bus.C_ACK, 4'b0100);
            chk("mw_data", bus.TX_DATA, mw_data[w]);
            chk("mw_pend", bus.TX_PEND, (w < 2));
            if (w < 2) begin
                set_word(2, 32'h0000_0070, mw_data[w+1], (w == 0));
            end else begin
                bus.C_REQ = 4'b0001;
            end
            send_word();
        end
        respond(1'b1, 1'b0, 4'b0100, 1'b1, 1'b0);
        tick();
        chk("wrap_cack", bus.C_ACK, 4'b0001);
        chk("wrap_addr", bus.TX_ADDR, 32'h0000_0040);
        bus.C_REQ = 4'b0000;
        send_word();
        respond(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1);

        // Asynchronous reset while TX_REQ is high.
        set_word(2, 32'h0000_0077, 32'h7777_7777, 1'b0);
        bus.C_REQ = 4'b0100;
        tick();
        bus.C_REQ = 4'b0000;
        tick();
        chk("rst_pre_txreq", bus.TX_REQ, 1'b1);
        RESETn_local = 1'b0;
        #1;
        chk("rst_txreq", bus.TX_REQ, 1'b0);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_txaddr", bus.TX_ADDR, 32'h0);
        chk("rst_cfail", bus.C_FAIL, 1'b0);
        tick();
        RESETn_local = 1'b1;

        // Priority class: pointer 0, all requesting, only requester 3 flagged.
        for (int i = 0; i < N; i++) begin
            set_word(i, 32'h10 + i, 32'hA0 + i, 1'b0);
        end
`ifdef MBUS_TX_ARB_PRIO_EN
        exp_g = 3;
`else
        exp_g = 0;
`endif
        bus.C_PRIORITY = 4'b1000;
        bus.C_REQ      = 4'b1111;
        tick();
        chk("prio_cack", bus.C_ACK, 4'b0001 << exp_g);
        chk("prio_txprio", bus.TX_PRIORITY, (exp_g == 3));
        bus.C_REQ      = 4'b0000;
        bus.C_PRIORITY = 4'b0000;
        send_word();
        respond(1'b1, 1'b0, 4'b0001 << exp_g, 1'b1, 1'b0);
        do_reset();

        // Continuous requests from all four: grants rotate 0,1,2,3,0.
        bus.C_REQ = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("rr_cack", bus.C_ACK, 4'b0001 << (k % 4));
            chk("rr_addr", bus.TX_ADDR, 32'h10 + (k % 4));
            chk("rr_no_done", bus.C_DONE, 4'b0000);
            if (k == 4) begin
                bus.C_REQ = 4'b0000;
            end
            send_word();
            respond(1'b1, 1'b0, 4'b0001 << (k % 4), 1'b1, 1'b0);
            if (k < 4) begin
                tick();
            end
        end

        // Node never acknowledges: watchdog of 16 cycles, then DRAIN acks a late TX_SUCC.
        bus.C_REQ = 4'b1000;
        tick();
        chk("to_cack", bus.C_ACK, 4'b1000);
        bus.C_REQ = 4'b0000;
        n_hi = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.TX_REQ === 1'b1) n_hi++;
        end
        chk("to_txreq_high_cycles", n_hi, 15);
        tick();
        chk("to_txreq_drop", bus.TX_REQ, 1'b0);
        chk("to_done", bus.C_DONE, 4'b1000);
        chk("to_fail", bus.C_FAIL, 1'b1);
        chk("to_timeout", bus.C_TIMEOUT, 1'b1);
        chk("to_succ", bus.C_SUCC, 1'b0);
        bus.TX_SUCC = 1'b1;
        tick();
        chk("drain_respack", bus.TX_RESP_ACK, 1'b1);
        chk("drain_busy", bus.BUSY, 1'b1);
        chk("drain_no_done", bus.C_DONE, 4'b0000);
        bus.TX_SUCC = 1'b0;
        tick();
        chk("drain_respack_low", bus.TX_RESP_ACK, 1'b0);
        chk("drain_idle", bus.BUSY, 1'b0);
        chk("drain_timeout_held", bus.C_TIMEOUT, 1'b1);

        // TX_SUCC and TX_FAIL together: FAIL wins.
        bus.C_REQ = 4'b0010;
        tick();
        chk("both_cack", bus.C_ACK, 4'b0010);
        bus.C_REQ = 4'b0000;
        send_word();
        respond(1'b1, 1'b1, 4'b0010, 1'b0, 1'b1);

        // Orphan TX_FAIL in IDLE blocks a pending grant until drained.
        bus.TX_FAIL = 1'b1;
        bus.C_REQ   = 4'b0001;
        tick();
        chk("orph_no_grant", bus.C_ACK, 4'b0000);
        chk("orph_busy", bus.BUSY, 1'b1);
        tick();
        chk("orph_respack", bus.TX_RESP_ACK, 1'b1);
        bus.TX_FAIL = 1'b0;
        tick();
        chk("orph_respack_low", bus.TX_RESP_ACK, 1'b0);
        chk("orph_still_no_grant", bus.C_ACK, 4'b0000);
        tick();
        chk("orph_grant", bus.C_ACK, 4'b0001);
        bus.C_REQ = 4'b0000;
        send_word();
        respond(1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbus_tx_arbiter.md
Name: mbus_tx_arbiter

Overview:
- Shares the single MBus node TX interface among NUM_REQ local requesters (e.g. layer controller, ICE host path, debug injector).
- Arbitration happens at message boundaries only; the grant is locked for a whole multi-word message.
- Sequences the node TX handshake: TX_REQ/TX_ACK per word, then TX_SUCC/TX_FAIL with TX_RESP_ACK.
- Adds a response watchdog. Sits beside the node inside the general layer wrapper, on CLK_EXT.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 20'h05fff, CLK_EXT cycles allowed per wait state before abort.

Ports:
- CLK_EXT  input  1  system clock.
- RESETn_local  input  1  asynchronous, active-low reset.
- C_REQ  input  NUM_REQ  per-requester word valid, level.
- C_ADDR  input  NUM_REQ*`ADDR_WIDTH  flattened destination addresses, requester i at slice i.
- C_DATA  input  NUM_REQ*`DATA_WIDTH  flattened data words.
- C_PEND  input  NUM_REQ  more words follow this one.
- C_PRIORITY  input  NUM_REQ  MBus priority request.
- C_ACK  output  NUM_REQ  1-cycle pulse: word latched; requester may present the next word.
- C_DONE  output  NUM_REQ  1-cycle pulse: message finished.
- C_SUCC, C_FAIL, C_TIMEOUT  output  1 each  status; valid in the C_DONE cycle, held until the next C_DONE.
- TX_ADDR  output  `ADDR_WIDTH  to node.
- TX_DATA  output  `DATA_WIDTH  to node.
- TX_PEND, TX_REQ, TX_PRIORITY  output  1 each  to node.
- TX_RESP_ACK  output  1  to node.
- TX_ACK, TX_SUCC, TX_FAIL  input  1 each  from node.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; watchdog 0.
- IDLE:
  - If any C_REQ is set, grant the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's ADDR/DATA/PEND/PRIORITY into the TX output registers and pulse C_ACK[g].
  - Go to WREQ; TX_REQ rises in the next cycle.
- WREQ:
  - TX_REQ=1; wait for TX_ACK=1, then drop TX_REQ and go to WACK.
- WACK:
  - Wait for TX_ACK=0.
  - If the latched PEND=1 and C_REQ[g]=1: latch the next word, pulse C_ACK[g], go to WREQ.
  - If the latched PEND=1 and C_REQ[g]=0: stay and wait; the watchdog applies.
  - If the latched PEND=0: go to RESP.
- RESP:
  - Wait for TX_SUCC or TX_FAIL. Latch both; set TX_RESP_ACK=1; go to RACK.
  - If both arrive in the same cycle, FAIL wins (C_SUCC=0, C_FAIL=1).
- RACK:
  - When TX_SUCC=0 and TX_FAIL=0: drop TX_RESP_ACK and pulse C_DONE[g].
  - Set pointer to g+1 mod NUM_REQ; go to IDLE.
- Latency: C_REQ rising in IDLE to TX_REQ high is 2 cycles. Node TX_ACK to arbiter TX_REQ low is 1 cycle.
- TX_ADDR/TX_DATA/TX_PEND/TX_PRIORITY are stable from TX_REQ rise until TX_ACK falls.
- Watchdog:
  - Counts in WREQ, WACK and RESP; clears on every state change.
  - On reaching TIMEOUT: drop TX_REQ, set C_FAIL=1 and C_TIMEOUT=1, pulse C_DONE[g], go to DRAIN.
- DRAIN:
  - Ack any late TX_SUCC/TX_FAIL with TX_RESP_ACK until both are low.
  - Wait for TX_ACK=0, then go to IDLE. No C_DONE is generated here.
- A TX_SUCC/TX_FAIL seen in IDLE (orphan response) also goes through DRAIN; new grants are blocked meanwhile.
- A requester dropping C_REQ before its first C_ACK withdraws cleanly.
- Grant index and pointer are $clog2(NUM_REQ) bits; wrap is explicit for non-power-of-2 NUM_REQ.
- Reset mid-message: everything returns to reset values immediately. The node is reset by the same source.

Optional Feature:
- Macro MBUS_TX_ARB_PRIO_EN.
- Defined: in IDLE, requesters with C_PRIORITY=1 form an upper class arbitrated round-robin among themselves. The lower class is served only when no priority request is pending.
- Undefined: C_PRIORITY only passes through to TX_PRIORITY; pure round-robin.

Decomposition:
- mbus_def.v holds the state encoding macros and a TX_ARB_TO_WIDTH constant (20).
- Sub-module mbus_rr_picker: combinational round-robin find-first with wrap (request vector, pointer in; one-hot plus index out). The priority build instantiates it twice.

Test Plan:
- Single word: C_REQ[1], ADDR 32'h0000_0050, DATA 32'hDEAD_BEEF, PEND=0; node ACKs then TX_SUCC → one C_ACK[1], C_DONE[1] with C_SUCC=1; TX_REQ high exactly 2 cycles after C_REQ.
- 3-word message from requester 2 with requester 0 also requesting → all 3 words sent back-to-back before requester 0's TX_REQ; next grant goes to 3 if requesting, else wraps to 0.
- All 4 requesting continuously → grants in order 0,1,2,3,0; each sees exactly one C_DONE per message.
- Node never ACKs, TIMEOUT=20'h00010 → TX_REQ drops after 16 cycles; C_DONE with C_FAIL=1, C_TIMEOUT=1; a late TX_SUCC is acked in DRAIN; BUSY then drops.
- TX_SUCC and TX_FAIL asserted together → C_FAIL=1, C_SUCC=0. Separately: RESETn_local pulsed in WREQ → all outputs 0 the same cycle.
- With MBUS_TX_ARB_PRIO_EN: pointer at 0, C_REQ=4'b1111, C_PRIORITY=4'b1000 → requester 3 granted first.
